ntt_frame_scheduler: RTL and testbench

- Sequences the streaming NTT core (N=2048, 64 coefficients/cycle, 32 beats per polynomial frame).
- Admits whole frames from an upstream valid/ready stream and drives the core's replicated start strobes.
- Tracks frames in flight, gates admission on downstream frame credits, and frames core output into valid/last beats.
- Measures per-frame core latency; sits between the ingress buffer and the NTT core/output FIFO.

---
 rtl/ntt_sched_pkg.sv | 24 ++
 rtl/ntt_ts_fifo.sv | 36 +++
 rtl/ntt_frame_scheduler.sv | 127 ++++++++++++
 tb/tb_ntt_frame_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_sched_pkg.sv
// Shared constants and types for the NTT frame scheduler.
// Beat and counter widths are derived from the frame geometry.
package ntt_sched_pkg;
    localparam int INPUT_PER_CYCLE = 64;
    localparam int N               = 2048;
    localparam int BEATS           = N / INPUT_PER_CYCLE;
    localparam int BEAT_W          = $clog2(BEATS);
    localparam int START_FANOUT    = 10;
    localparam int MAX_INFLIGHT    = 4;
    localparam int INFL_W          = $clog2(MAX_INFLIGHT + 1);
    localparam int OUT_CREDITS     = 4;
    localparam int CRED_W          = $clog2(OUT_CREDITS + 1);
    localparam int LAT_W           = 16;

    localparam int ERR_UNDERRUN   = 0;
    localparam int ERR_SPURIOUS   = 1;
    localparam int ERR_OVERLAP    = 2;
    localparam int ERR_CREDIT_OVF = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/ntt_ts_fifo.sv
// Small FIFO of core-start timestamps, one entry per frame inside the core.
// Occupancy is tracked by the scheduler, so only the pointers live here.
module ntt_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/ntt_frame_scheduler.sv
// Admits whole frames into the streaming NTT core, tracks frames in flight and
// downstream credits, frames core output into beats and measures core latency.
//   state  | meaning
//   IDLE   | waiting for an admissible first beat
//   STREAM | passing the remaining beats of the admitted frame
module ntt_frame_scheduler
    import ntt_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [START_FANOUT-1:0] core_in_start,
    output logic                    core_in_zero,
    input  logic                    core_out_start,
    output logic                    m_valid,
    output logic                    m_last,
    output logic [BEAT_W-1:0]       m_beat_idx,
    input  logic                    m_credit_ret,
    output logic                    busy,
    output logic                    lat_valid,
    output logic [LAT_W-1:0]        lat_cycles,
    output logic [3:0]              err
);
    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [CRED_W-1:0] credits;
    logic [INFL_W-1:0] inflight;
    logic [LAT_W-1:0]  ts_cnt;
    logic [LAT_W-1:0]  ts_head;
    logic              can_admit;
    logic              admit;
    logic              out_ok;

    assign can_admit = en && (credits != '0) && (inflight < INFL_W'(MAX_INFLIGHT));
    assign s_ready   = !rst && ((state == STREAM) || can_admit);
    assign admit     = (state == IDLE) && s_valid && s_ready;
    assign out_ok    = core_out_start && (inflight != '0);
    assign busy      = (state == STREAM) || (inflight != '0) || m_valid;

    // Stamp with the cycle core_in_start is high, one after the admit beat.
    ntt_ts_fifo #(.DEPTH(MAX_INFLIGHT), .W(LAT_W)) u_ts_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (admit),
        .pop     (out_ok),
        .wr_data (ts_cnt + LAT_W'(1)),
        .rd_data (ts_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            credits       <= CRED_W'(OUT_CREDITS);
            inflight      <= '0;
            ts_cnt        <= '0;
            core_in_start <= '0;
            core_in_zero  <= 1'b0;
            m_valid       <= 1'b0;
            m_last        <= 1'b0;
            m_beat_idx    <= '0;
            lat_valid     <= 1'b0;
            lat_cycles    <= '0;
            err           <= '0;
        end else begin
            ts_cnt        <= ts_cnt + LAT_W'(1);
            core_in_start <= {START_FANOUT{admit}};
            core_in_zero  <= (state == STREAM) && !s_valid;

            case (state)
                IDLE: begin
                    if (admit) begin
                        beat_cnt <= BEAT_W'(1);
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                    if (beat_cnt == BEAT_W'(BEATS - 1)) begin
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                    if (!s_valid) err[ERR_UNDERRUN] <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            case ({admit, m_credit_ret})
                2'b10: credits <= credits - CRED_W'(1);
                2'b01: begin
                    if (credits == CRED_W'(OUT_CREDITS)) err[ERR_CREDIT_OVF] <= 1'b1;
                    else                                 credits <= credits + CRED_W'(1);
                end
                default: ;
            endcase

            case ({admit, out_ok})
                2'b10:   inflight <= inflight + INFL_W'(1);
                2'b01:   inflight <= inflight - INFL_W'(1);
                default: ;
            endcase

            if (core_out_start && !out_ok) err[ERR_SPURIOUS] <= 1'b1;

            lat_valid <= out_ok;
            if (out_ok) lat_cycles <= ts_cnt - ts_head;

            if (out_ok) begin
                if (m_valid && !m_last) err[ERR_OVERLAP] <= 1'b1;
                m_valid    <= 1'b1;
                m_beat_idx <= '0;
                m_last     <= 1'b0;
            end else if (m_valid) begin
                if (m_last) begin
                    m_valid    <= 1'b0;
                    m_last     <= 1'b0;
                    m_beat_idx <= '0;
                end else begin
                    m_beat_idx <= m_beat_idx + BEAT_W'(1);
                    m_last     <= (m_beat_idx == BEAT_W'(BEATS - 2));
                end
            end
        end
    end
endmodule

// File: tb/tb_ntt_frame_scheduler.sv
// Scoreboard bench for ntt_frame_scheduler: stimulus queues expected start
// cycles, latencies and output beats; a negedge monitor pops and compares.
module tb_ntt_frame_scheduler;
    import ntt_sched_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic                    s_valid;
    logic                    s_ready;
    logic [START_FANOUT-1:0] core_in_start;
    logic                    core_in_zero;
    logic                    core_out_start;
    logic                    m_valid;
    logic                    m_last;
    logic [BEAT_W-1:0]       m_beat_idx;
    logic                    m_credit_ret;
    logic                    busy;
    logic                    lat_valid;
    logic [LAT_W-1:0]        lat_cycles;
    logic [3:0]              err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_wait = 0;
    int exp_start[$];
    int exp_lat[$];
    int exp_beat[$];
    int st_cyc[$];

    ntt_frame_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .core_in_start  (core_in_start),
        .core_in_zero   (core_in_zero),
        .core_out_start (core_out_start),
        .m_valid        (m_valid),
        .m_last         (m_last),
        .m_beat_idx     (m_beat_idx),
        .m_credit_ret   (m_credit_ret),
        .busy           (busy),
        .lat_valid      (lat_valid),
        .lat_cycles     (lat_cycles),
        .err            (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every DUT-presented event must match the head of its queue.
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            if (core_in_start != '0) begin
                if (exp_start.size() == 0) chk("unexpected_in_start", core_in_start, 0);
                else begin
                    e = exp_start.pop_front();
                    chk("in_start_cycle", cyc, e);
                    chk("in_start_bits", core_in_start, 10'h3FF);
                end
            end
            if (lat_valid) begin
                if (exp_lat.size() == 0) chk("unexpected_lat", lat_valid, 0);
                else begin
                    e = exp_lat.pop_front();
                    chk("lat_cycles", lat_cycles, e);
                end
            end
            if (m_valid) begin
                if (exp_beat.size() == 0) chk("unexpected_beat", m_valid, 0);
                else begin
                    e = exp_beat.pop_front();
                    chk("out_beat_idx_last", {m_beat_idx, m_last}, e);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        core_out_start = 1'b0;
        m_credit_ret = 1'b0;
        step(2);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_in_start", core_in_start, 0);
        chk("rst_in_zero", core_in_zero, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_beat_idx", m_beat_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lat_valid", lat_valid, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        st_cyc.delete();
    endtask

    // Drives nb beats of a frame starting with an admit; beat zb is sent invalid.
    task automatic send_frame(input int zb, input int nb);
        int t;
        t = 0;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        last_wait = t;
        chk("admit_ready", s_ready, 1);
        exp_start.push_back(cyc + 1);
        st_cyc.push_back(cyc + 1);
        @(posedge clk);
        #1;
        for (int b = 1; b < nb; b++) begin
            s_valid = (b != zb);
            @(negedge clk);
            chk("stream_ready", s_ready, 1);
            chk("in_zero", core_in_zero, (b - 1) == zb);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic core_ret(input int lat, input int nb);
        core_out_start = 1'b1;
        exp_lat.push_back(lat & 16'hFFFF);
        for (int i = 0; i < nb; i++) exp_beat.push_back(i * 2 + ((i == BEATS - 1) ? 1 : 0));
        step(1);
        core_out_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en = 1'b0;
        s_valid = 1'b0;
        core_out_start = 1'b0;
        m_credit_ret = 1'b0;
        do_reset();
        en = 1'b1;

        // Single frame, then core returns it 100 cycles after in_start.
        send_frame(-1, BEATS);
        s_valid = 1'b0;
        while (cyc < st_cyc[0] + 100) step(1);
        chk("t2_busy_inflight", busy, 1);
        core_ret(100, BEATS);
        step(BEATS);
        @(negedge clk);
        chk("t2_busy_drop", busy, 0);
        chk("t2_m_valid_drop", m_valid, 0);
        @(posedge clk);
        #1;

        // Four back-to-back frames exhaust credits; one return re-opens admission.
        do_reset();
        for (int f = 0; f < 4; f++) begin
            send_frame(-1, BEATS);
            chk("t3_back_to_back", last_wait, 0);
        end
        s_valid = 1'b0;
        core_ret(cyc - st_cyc[0], BEATS);
        step(BEATS);
        s_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t3_no_credit_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        m_credit_ret = 1'b1;
        step(1);
        m_credit_ret = 1'b0;
        send_frame(-1, BEATS);
        chk("t3_after_credit", last_wait, 0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("t3_err", err, 0);
        @(posedge clk);
        #1;

        // Underrun on beat 10: zero strobe, sticky flag, frame still 32 beats.
        do_reset();
        send_frame(10, BEATS);
        s_valid = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("t4_in_zero_after", core_in_zero, 0);
        chk("t4_err", err, 4'b0001);
        chk("t4_frame_ended", s_ready, 0);
        @(posedge clk);
        #1;
        en = 1'b1;

        // Spurious core_out_start, then an overlapping restart at beat 5.
        do_reset();
        core_out_start = 1'b1;
        step(1);
        core_out_start = 1'b0;
        @(negedge clk);
        chk("t5_spurious_err", err, 4'b0010);
        chk("t5_spurious_m_valid", m_valid, 0);
        chk("t5_spurious_lat", lat_valid, 0);
        @(posedge clk);
        #1;
        send_frame(-1, BEATS);
        send_frame(-1, BEATS);
        s_valid = 1'b0;
        step(5);
        core_ret(cyc - st_cyc[0], 6);
        step(5);
        core_ret(cyc - st_cyc[1], BEATS);
        step(BEATS);
        @(negedge clk);
        chk("t5_overlap_err", err, 4'b0110);
        chk("t5_busy_drop", busy, 0);
        @(posedge clk);
        #1;

        // Reset at beat 15, fresh frame, then credit overflow shows credits were 4.
        do_reset();
        send_frame(-1, 15);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        chk("t6_s_ready", s_ready, 0);
        chk("t6_in_start", core_in_start, 0);
        chk("t6_in_zero", core_in_zero, 0);
        chk("t6_m_valid", m_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_lat_valid", lat_valid, 0);
        chk("t6_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        st_cyc.delete();
        send_frame(-1, BEATS);
        chk("t6_fresh_admit", last_wait, 0);
        s_valid = 1'b0;
        m_credit_ret = 1'b1;
        step(1);
        @(negedge clk);
        chk("t6_ret_no_ovf", err, 0);
        @(posedge clk);
        #1;
        step(1);
        m_credit_ret = 1'b0;
        @(negedge clk);
        chk("t6_credit_ovf", err, 4'b1000);
        @(posedge clk);
        #1;

        step(2);
        chk("start_queue_drained", exp_start.size(), 0);
        chk("lat_queue_drained", exp_lat.size(), 0);
        chk("beat_queue_drained", exp_beat.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
